// File: rtl/add_issue_ctrl.sv
// rtl/add_issue_ctrl.sv - operand FIFO and issue/capture controller for a fixed-latency registered adder
// One operation outstanding at a time; carry is computed locally from the popped operands.
module add_issue_ctrl #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic                     start,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  input  logic [W-1:0]             y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic                     res_carry,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]    mem_a [DEPTH];
  logic [W-1:0]    mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  logic [CNTW-1:0] wcnt;
  logic            carry_q;

  assign in_ready   = (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign fifo_count = count;
  assign start      = (state == ISSUE);
  assign busy       = (state != IDLE);

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wcnt == '0) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      carry_q   <= 1'b0;
      wcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
    end else begin
      if (pop) begin
        a       <= mem_a[rd_ptr];
        b       <= mem_b[rd_ptr];
        carry_q <= 1'((({1'b0, mem_a[rd_ptr]} + {1'b0, mem_b[rd_ptr]}) >> W));
      end
      if (state == ISSUE) begin
        wcnt <= CNTW'(LAT - 1);
      end else if (state == WAIT && wcnt != '0) begin
        wcnt <= wcnt - CNTW'(1);
      end
      // y is already settled with the new sum on the edge where the countdown hits zero.
      if (state == WAIT && wcnt == '0) begin
        res_data  <= y;
        res_carry <= carry_q;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// tb/tb_add_issue_ctrl.sv - randomized and directed bench for add_issue_ctrl with a timeline reference model
module tb_add_issue_ctrl;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_ready, start, res_valid, res_carry, busy;
  logic [W-1:0]  a, b, y, res_data;
  logic [CW-1:0] fifo_count;

  add_issue_ctrl #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .a(a), .b(b), .y(y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Registered adder: sum enters on the start-sample edge, y shows it LAT-1 edges later.
  logic [W-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (start) pipe[0] <= a + b;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign y = pipe[LAT-1];

  int passed = 0;
  int total  = 0;
  int n_start = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: queue of pending pairs and the elapsed edges since the issue edge.
  logic [W-1:0] qa[$], qb[$];
  int           e = -1;
  logic [W-1:0] m_a = '0, m_b = '0, m_rd = '0;
  logic         m_rv = 1'b0, m_rc = 1'b0;

  task automatic model_reset();
    qa.delete(); qb.delete();
    e = -1; m_a = '0; m_b = '0; m_rd = '0; m_rv = 1'b0; m_rc = 1'b0;
  endtask

  task automatic model_step();
    logic [W:0] s;
    bit do_push;
    do_push = in_valid && (qa.size() < DEPTH);
    if (e < 0) begin
      if (qa.size() > 0) begin
        m_a = qa.pop_front();
        m_b = qb.pop_front();
        e = 0;
      end
    end else if (m_rv) begin
      if (res_ready) begin
        m_rv = 1'b0;
        e = -1;
      end
    end else begin
      e++;
      if (e == LAT + 1) begin
        s = {1'b0, m_a} + {1'b0, m_b};
        m_rv = 1'b1;
        m_rd = s[W-1:0];
        m_rc = s[W];
      end
    end
    if (do_push) begin
      qa.push_back(in_a);
      qb.push_back(in_b);
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    if (start) n_start++;
    chk("start",      32'(start),      32'(e == 0));
    chk("busy",       32'(busy),       32'(e >= 0));
    chk("a",          32'(a),          32'(m_a));
    chk("b",          32'(b),          32'(m_b));
    chk("res_valid",  32'(res_valid),  32'(m_rv));
    chk("res_data",   32'(res_data),   32'(m_rd));
    chk("res_carry",  32'(res_carry),  32'(m_rc));
    chk("fifo_count", 32'(fifo_count), 32'(qa.size()));
    chk("in_ready",   32'(in_ready),   32'(qa.size() < DEPTH));
  end

  task automatic push_pair(input logic [W-1:0] pa, input logic [W-1:0] pb);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = pa; in_b = pb;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [W-1:0] pa, input logic [W-1:0] pb,
                            input logic [W-1:0] exp_d, input logic exp_c, input string tag);
    int s_k, r_k, ns;
    logic [W-1:0] d;
    logic c;
    s_k = -1; r_k = -1; ns = 0; d = '0; c = 1'b0;
    res_ready = 1'b1;
    push_pair(pa, pb);
    for (int k = 0; k < 30; k++) begin
      if (start) begin
        ns++;
        if (s_k < 0) s_k = k;
      end
      if (res_valid && r_k < 0) begin
        r_k = k; d = res_data; c = res_carry;
      end
      @(negedge clk);
    end
    chk({tag, "_starts"},  32'(ns),        32'd1);
    chk({tag, "_latency"}, 32'(r_k - s_k), 32'd3);
    chk({tag, "_data"},    32'(d),         32'(exp_d));
    chk({tag, "_carry"},   32'(c),         32'(exp_c));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"},      32'(start),      32'd0);
    chk({tag, "_a"},          32'(a),          32'd0);
    chk({tag, "_b"},          32'(b),          32'd0);
    chk({tag, "_res_valid"},  32'(res_valid),  32'd0);
    chk({tag, "_res_data"},   32'(res_data),   32'd0);
    chk({tag, "_res_carry"},  32'(res_carry),  32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [W-1:0] ba [5];
  logic [W-1:0] bb [5];
  logic [W:0]   bs;
  int           got, n, peak;

  initial begin
    ba = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'hAAAA};
    bb = '{16'h0002, 16'h8000, 16'h0001, 16'h4321, 16'h5556};

    #2 rst = 1'b1;
    #1 chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    run_single(16'h0003, 16'h0004, 16'h0007, 1'b0, "single");
    run_single(16'hFFFF, 16'h0002, 16'h0001, 1'b1, "overflow");

    // Burst under backpressure: one pair goes in flight, four wait in the FIFO.
    res_ready = 1'b0;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      push_pair(ba[i], bb[i]);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("burst_peak", 32'(peak), 32'd4);
    chk("burst_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h1111;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("burst_extra_waits", 32'(fifo_count), 32'd4);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("burst_first_valid", 32'(res_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      bs = {1'b0, ba[0]} + {1'b0, bb[0]};
      chk("hold_data",  32'(res_data),  32'(bs[W-1:0]));
      chk("hold_carry", 32'(res_carry), 32'(bs[W]));
      chk("hold_nostart", 32'(start), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("release_idle_nostart", 32'(start), 32'd0);
    @(negedge clk);
    chk("release_next_start", 32'(start), 32'd1);
    got = 1;
    n = 0;
    while (got < 5 && n < 100) begin
      if (res_valid) begin
        bs = {1'b0, ba[got]} + {1'b0, bb[got]};
        chk("burst_order_data",  32'(res_data),  32'(bs[W-1:0]));
        chk("burst_order_carry", 32'(res_carry), 32'(bs[W]));
        got++;
      end
      @(negedge clk);
      n++;
    end
    chk("burst_all_results", 32'(got), 32'd5);
    repeat (10) @(negedge clk);

    // Push lands on the same edge as the IDLE pop while one item is pending.
    push_pair(16'h0101, 16'h0202);
    push_pair(16'h0303, 16'h0404);
    chk("simul_push_pop_count", 32'(fifo_count), 32'd1);
    chk("simul_push_pop_start", 32'(start), 32'd1);
    repeat (20) @(negedge clk);

    n_start = 0;
    for (int k = 0; k < 500; k++) begin
      in_valid  = 1'($urandom_range(1, 0));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      res_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("wrap_ops_issued", 32'(n_start >= 3 * DEPTH), 32'd1);
    chk("drained_count", 32'(fifo_count), 32'd0);

    // Asynchronous reset while WAIT is pending and two pairs are queued.
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    push_pair(16'h5555, 16'h6666);
    chk("pre_rst_busy",  32'(busy),       32'd1);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_start", 32'(start),      32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("post_rst_no_result", 32'(res_valid), 32'd0);
      chk("post_rst_no_start",  32'(start),     32'd0);
      @(negedge clk);
    end
    run_single(16'h0010, 16'h0020, 16'h0030, 1'b0, "fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
